zion_rc_skid_buffer: RTL and testbench
======================================

// Module: zion_rc_skid_buffer
// PURPOSE
//   Fully registered valid/ready pipeline slice: the handshake counterpart of the plain reset DFF.
//   Registers the forward path (data, valid) and the backward path (ready) so that long
//   stream paths can be cut without combinational ready chains.
//   Two entries (main + skid), full throughput (1 beat/cycle), 1-cycle forward latency.
//   Sits between any producer/consumer pair that uses the iVld/iRdy, oVld/oRdy protocol.
// PARAMETERS
//   WIDTH     default 8    data width of iDat/oDat, >=1
//   INI_DATA  default '0   reset value of main and skid data registers (and therefore oDat)
// PORTS
//   clk   in   1      clock, all logic on posedge
//   rst   in   1      synchronous reset, active low
//   iVld  in   1      upstream beat valid
//   iRdy  out  1      upstream ready; registered output
//   iDat  in   WIDTH  upstream data
//   oVld  out  1      downstream beat valid; registered output
//   oRdy  in   1      downstream ready
//   oDat  out  WIDTH  downstream data; driven directly from main register
// BEHAVIOUR
// - Reset: one clock, one synchronous active-low reset (rst low sampled at posedge).
//   On reset: state=EMPTY, oVld=0, iRdy=0, main=skid=INI_DATA, so oDat=INI_DATA.
//   iRdy rises on the first posedge with rst high; no beat is accepted while rst is low.
// - Transfers: in-beat = iVld&iRdy at posedge; out-beat = oVld&oRdy at posedge.
// - States (2-bit): EMPTY (0 entries), BUSY (1, in main), FULL (2, main+skid).
//   oVld = (state!=EMPTY); iRdy = registered (next_state!=FULL).
// - EMPTY: in-beat -> BUSY, main<=iDat. Otherwise stay.
//   oRdy while EMPTY has no effect.
// - BUSY:  in & out   -> BUSY, main<=iDat (pass-through, 1 beat/cycle).
//          in only    -> FULL, skid<=iDat, iRdy<=0.
//          out only   -> EMPTY.
//          neither    -> BUSY, main held.
// - FULL:  iRdy=0, iVld ignored, iDat not sampled.
//          out-beat   -> BUSY, main<=skid, iRdy<=1.
//          no out     -> FULL, both registers held.
// - Ordering: strict FIFO; no beat dropped or duplicated under any iVld/oRdy pattern.
// - Latency: beat accepted at edge N is visible on oDat/oVld after edge N.
//   From FULL, one extra cycle per skid beat.
// - Stability: while oVld=1 and oRdy=0, oVld and oDat hold constant
//   (AXI-style no-retract on the output side).
// - iVld may toggle freely when iRdy=0; the block never reads iDat then.
// - Skid register is written only on the BUSY->FULL transition.
//   Skid contents are don't-care otherwise but are never X after reset.
// - Reset mid-operation: rst low overrides all transfers that edge.
//   Contents in main/skid are discarded; outputs return to reset values next cycle.
// - Parameter check: WIDTH<1 -> $error at elaboration/initial.
//   $finish if CHECK_ERR_EXIT is defined.
// TESTING
// 1 Reset: hold rst=0 3 cycles with iVld=1, iDat=8'hA5
//   -> oVld=0, iRdy=0, oDat=INI_DATA; after release iRdy=1 next edge, no beat taken.
// 2 Streaming: oRdy=1, iVld=1, iDat=1..16 on consecutive cycles
//   -> oDat=1..16 one cycle later, no bubbles, iRdy stays 1.
// 3 Backpressure: send 8'h11,8'h22 with oRdy=0 -> FULL, iRdy=0, oDat=8'h11 held.
//   Raise oRdy -> 8'h11 then 8'h22 out, iRdy=1 after first out-beat.
// 4 Random: random iVld/oRdy (50%), 1000 beats, incrementing data
//   -> scoreboard exact order, no loss/dup, oDat stable while oVld&!oRdy.
// 5 Mid-op reset: FULL with 8'h33/8'h44, pulse rst=0 one cycle
//   -> oVld=0, iRdy=0, oDat=INI_DATA; neither 8'h33 nor 8'h44 ever emerges.
// 6 Param: WIDTH=1 and WIDTH=64, INI_DATA=all-ones -> reset oDat all-ones; test 2 passes.

Source files
------------

// File: rtl/zion_rc_skid_buffer.sv
// rtl/zion_rc_skid_buffer.sv - two-entry registered valid/ready pipeline slice
// Main register drives oDat; the skid register catches the beat that lands while ready is falling.
module zion_rc_skid_buffer #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iVld,
    output logic             iRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             oRdy,
    output logic [WIDTH-1:0] oDat
);

    if (WIDTH < 1) begin : g_bad_width
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_rc_skid_buffer: WIDTH must be >= 1");
`else
        $error("zion_rc_skid_buffer: WIDTH must be >= 1");
`endif
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             irdy_q;
    logic             in_beat;
    logic             out_beat;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign in_beat  = iVld & irdy_q;
    assign out_beat = oVld & oRdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= EMPTY;
            irdy_q <= 1'b0;
            main_q <= INI_DATA;
            skid_q <= INI_DATA;
        end else begin
            state  <= next_state;
            // Ready is a flop: it looks one state ahead so it drops on the edge that fills the skid.
            irdy_q <= (next_state != FULL);
            if (load_main) begin
                main_q <= iDat;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= iDat;
            end
        end
    end

    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_beat) begin
                    next_state = BUSY;
                    load_main  = 1'b1;
                end
            end
            BUSY: begin
                if (in_beat && out_beat) begin
                    load_main = 1'b1;
                end else if (in_beat) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (out_beat) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_beat) begin
                    next_state     = BUSY;
                    main_from_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        oVld = (state != EMPTY);
        iRdy = irdy_q;
        oDat = main_q;
    end

endmodule

// File: tb/tb_zion_rc_skid_buffer.sv
// tb/tb_zion_rc_skid_buffer.sv - randomized scoreboard bench for zion_rc_skid_buffer
module tb_zion_rc_skid_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iVld = 1'b0;
    logic        oRdy = 1'b0;
    logic [7:0]  iDat = 8'h00;
    logic        iRdy, oVld;
    logic [7:0]  oDat;
    logic        iRdy1, oVld1, oDat1;
    logic        iRdy64, oVld64;
    logic [63:0] oDat64;
    logic [63:0] iDat64;

    assign iDat64 = {8{iDat}};

    always #5 clk = ~clk;

    zion_rc_skid_buffer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .iVld(iVld), .iRdy(iRdy), .iDat(iDat),
        .oVld(oVld), .oRdy(oRdy), .oDat(oDat)
    );

    zion_rc_skid_buffer #(.WIDTH(1), .INI_DATA(1'b1)) dut_w1 (
        .clk(clk), .rst(rst), .iVld(iVld), .iRdy(iRdy1), .iDat(iDat[0]),
        .oVld(oVld1), .oRdy(oRdy), .oDat(oDat1)
    );

    zion_rc_skid_buffer #(.WIDTH(64), .INI_DATA({64{1'b1}})) dut_w64 (
        .clk(clk), .rst(rst), .iVld(iVld), .iRdy(iRdy64), .iDat(iDat64),
        .oVld(oVld64), .oRdy(oRdy), .oDat(oDat64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of accepted beats, capacity two.
    logic [7:0] q[$];
    logic       prev_rst_low = 1'b1;
    logic       hold_prev    = 1'b0;
    logic [7:0] prev_dat     = 8'h00;

    always @(negedge clk) begin
        if (prev_rst_low) begin
            chk("rst_ovld",   64'(oVld),   64'd0);
            chk("rst_irdy",   64'(iRdy),   64'd0);
            chk("rst_odat",   64'(oDat),   64'h00);
            chk("rst_odat_w1", 64'(oDat1), 64'd1);
            chk("rst_odat_w64", oDat64,    {64{1'b1}});
        end else begin
            chk("ovld_occupancy", 64'(oVld), 64'(q.size() != 0));
            chk("irdy_occupancy", 64'(iRdy), 64'(q.size() < 2));
            chk("w1_ovld",  64'(oVld1),  64'(q.size() != 0));
            chk("w64_irdy", 64'(iRdy64), 64'(q.size() < 2));
            if (q.size() != 0) begin
                chk("odat_head",     64'(oDat),  64'(q[0]));
                chk("odat_head_w1",  64'(oDat1), 64'(q[0][0]));
                chk("odat_head_w64", oDat64,     {8{q[0]}});
            end
            if (hold_prev) begin
                chk("hold_ovld", 64'(oVld), 64'd1);
                chk("hold_odat", 64'(oDat), 64'(prev_dat));
            end
        end
        hold_prev    = oVld && !oRdy && rst;
        prev_dat     = oDat;
        prev_rst_low = !rst;
        if (!rst) begin
            q.delete();
        end else begin
            if (oVld && oRdy) begin
                chk("pop_has_entry", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) void'(q.pop_front());
            end
            if (iVld && iRdy) q.push_back(iDat);
        end
    end

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int iter;
        logic take;

        // reset held with a valid beat offered
        rst = 1'b0; iVld = 1'b1; iDat = 8'hA5; oRdy = 1'b1;
        cycle(3);
        rst = 1'b1; iVld = 1'b0;
        cycle(1);
        chk("irdy_after_release", 64'(iRdy), 64'd1);
        chk("no_beat_after_release", 64'(oVld), 64'd0);
        cycle(2);

        // streaming
        for (int i = 1; i <= 16; i++) begin
            iVld = 1'b1; iDat = 8'(i); oRdy = 1'b1;
            cycle(1);
            chk("stream_odat", 64'(oDat), 64'(i));
        end
        iVld = 1'b0;
        cycle(3);

        // backpressure into FULL
        oRdy = 1'b0;
        iVld = 1'b1; iDat = 8'h11; cycle(1);
        iDat = 8'h22; cycle(1);
        iVld = 1'b0; iDat = 8'hEE; cycle(3);
        chk("bp_irdy_low", 64'(iRdy), 64'd0);
        chk("bp_odat_held", 64'(oDat), 64'h11);
        oRdy = 1'b1; cycle(1);
        chk("bp_second_out", 64'(oDat), 64'h22);
        chk("bp_irdy_back", 64'(iRdy), 64'd1);
        cycle(3);

        // random handshakes
        sent = 0; iter = 0;
        iVld = 1'b0;
        while (sent < 1000 && iter < 10000) begin
            iVld = 1'($urandom_range(0, 1));
            oRdy = 1'($urandom_range(0, 1));
            iDat = iVld ? 8'(sent + 1) : 8'($urandom);
            @(negedge clk);
            take = iVld && iRdy;
            cycle(1);
            if (take) sent++;
            iter++;
        end
        chk("random_beats_sent", 64'(sent), 64'd1000);
        iVld = 1'b0; oRdy = 1'b1;
        cycle(4);

        // reset while FULL
        oRdy = 1'b0;
        iVld = 1'b1; iDat = 8'h33; cycle(1);
        iDat = 8'h44; cycle(1);
        iVld = 1'b0; cycle(2);
        chk("midrst_full", 64'(iRdy), 64'd0);
        rst = 1'b0; cycle(1);
        rst = 1'b1; oRdy = 1'b1;
        cycle(6);
        chk("midrst_nothing_out", 64'(oVld), 64'd0);

        // re-stream after reset to exercise all widths again
        for (int i = 1; i <= 16; i++) begin
            iVld = 1'b1; iDat = 8'(i + 100); cycle(1);
        end
        iVld = 1'b0;
        cycle(4);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
